// File: rtl/nios_system_key_pio_in.sv
// Avalon-MM input PIO: synchronises and debounces external key/switch lines,
// captures edges into a write-1-to-clear register and raises a masked level
// interrupt. Four-word register map, registered read data (latency 1).
module nios_system_key_pio_in #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_MASK = 2'd1,
    ADDR_RSVD = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] debounced_q, debounced_d;
  logic [WIDTH-1:0] debounced_dly_q, debounced_dly_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] edge_det;
  logic             wr;
  reg_addr_e        addr;

  // Writedata bits above WIDTH have no destination.
  logic unused_wd;
  generate
    if (WIDTH < 32) begin : g_unused_wd
      assign unused_wd = ^writedata[31:WIDTH];
    end else begin : g_no_unused_wd
      assign unused_wd = 1'b0;
    end
  endgenerate

  assign wr   = chipselect & ~write_n;
  assign addr = reg_addr_e'(address);

  // Synchroniser chain and per-bit debounce counters.
  always_comb begin
    sync1_d         = in_port;
    sync2_d         = sync1_q;
    debounced_d     = debounced_q;
    debounced_dly_d = debounced_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != debounced_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          debounced_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Edge selection, mask/capture register writes and read mux.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = debounced_q & ~debounced_dly_q;
      1:       edge_det = ~debounced_q & debounced_dly_q;
      default: edge_det = debounced_q ^ debounced_dly_q;
    endcase

    irq_mask_d = irq_mask_q;
    if (wr && addr == ADDR_MASK) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end

    // A new edge is OR-ed in after the clear so that set wins on a collision.
    edge_capture_d = edge_capture_q | edge_det;
    if (wr && addr == ADDR_EDGE) begin
      edge_capture_d = (edge_capture_q & ~writedata[WIDTH-1:0]) | edge_det;
    end

    readdata_d = '0;
    case (addr)
      ADDR_DATA: readdata_d[WIDTH-1:0] = debounced_q;
      ADDR_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_RSVD: readdata_d            = '0;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_capture_q;
      default:   readdata_d            = '0;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q         <= '0;
      sync2_q         <= '0;
      debounced_q     <= '0;
      debounced_dly_q <= '0;
      irq_mask_q      <= '0;
      edge_capture_q  <= '0;
      readdata_q      <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      debounced_q     <= debounced_d;
      debounced_dly_q <= debounced_dly_d;
      irq_mask_q      <= irq_mask_d;
      edge_capture_q  <= edge_capture_d;
      readdata_q      <= readdata_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_nios_system_key_pio_in.sv
// Bench for the input PIO: three instances (rising/falling/any edge) share
// one bus and input stimulus; each is checked every cycle against a
// history-window reference model, plus a constant vector table and
// hand-written corner-case sequences.
module tb_nios_system_key_pio_in;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr = '0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wd = '0;
  logic [3:0]  inp = '0;
  logic [31:0] rd [3];
  logic        irq [3];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nios_system_key_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(rst_n), .address(addr), .chipselect(cs), .write_n(wn),
    .writedata(wd), .in_port(inp), .readdata(rd[0]), .irq(irq[0]));
  nios_system_key_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(rst_n), .address(addr), .chipselect(cs), .write_n(wn),
    .writedata(wd), .in_port(inp), .readdata(rd[1]), .irq(irq[1]));
  nios_system_key_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(rst_n), .address(addr), .chipselect(cs), .write_n(wn),
    .writedata(wd), .in_port(inp), .readdata(rd[2]), .irq(irq[2]));

  // Reference model state: h[0] is the most recently sampled in_port value.
  logic [3:0]  h [8];
  logic [3:0]  m_deb [3], m_dly [3], m_ec [3], m_mask [3];
  logic [31:0] m_rd [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare every instance shortly after.
  task automatic tick();
    logic [3:0] edg, ndeb;
    logic       wr, v, same;
    @(posedge clk);
    wr = cs && !wn;
    if (!rst_n) begin
      for (int e = 0; e < 3; e++) begin
        m_deb[e] = '0; m_dly[e] = '0; m_ec[e] = '0; m_mask[e] = '0; m_rd[e] = '0;
      end
      for (int j = 0; j < 8; j++) h[j] = '0;
    end else begin
      // Debounced bit follows the synchronised input once the last DC
      // synchronised samples (in_port delayed two edges) agree and differ.
      ndeb = m_deb[0];
      for (int b = 0; b < 4; b++) begin
        v = h[1][b];
        same = 1'b1;
        for (int j = 1; j <= DC; j++) if (h[j][b] != v) same = 1'b0;
        if (same && v != m_deb[0][b]) ndeb[b] = v;
      end
      for (int e = 0; e < 3; e++) begin
        if (e == 0)      edg = m_deb[e] & ~m_dly[e];
        else if (e == 1) edg = ~m_deb[e] & m_dly[e];
        else             edg = m_deb[e] ^ m_dly[e];
        case (addr)
          2'd0: m_rd[e] = {28'b0, m_deb[e]};
          2'd1: m_rd[e] = {28'b0, m_mask[e]};
          2'd2: m_rd[e] = '0;
          default: m_rd[e] = {28'b0, m_ec[e]};
        endcase
        m_ec[e] = ((wr && addr == 2'd3) ? (m_ec[e] & ~wd[3:0]) : m_ec[e]) | edg;
        if (wr && addr == 2'd1) m_mask[e] = wd[3:0];
        m_dly[e] = m_deb[e];
        m_deb[e] = ndeb;
      end
      for (int j = 7; j > 0; j--) h[j] = h[j-1];
      h[0] = inp;
    end
    #1;
    for (int e = 0; e < 3; e++) begin
      chk($sformatf("model_rd[%0d]", e), rd[e], m_rd[e]);
      chk($sformatf("model_irq[%0d]", e), {31'b0, irq[e]}, {31'b0, |(m_ec[e] & m_mask[e])});
    end
  endtask

  task automatic bus(input logic c, input logic w_n, input logic [1:0] a, input logic [31:0] d);
    cs = c; wn = w_n; addr = a; wd = d;
  endtask

  typedef struct {
    logic        rst_n;
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        32'h0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'hF,        32'h0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'hFFFFFFFF, 32'h0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 2'd3, 32'h0,        32'h0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h0,        32'hF, 1'b0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 2'd1, 32'h0,        32'hF, 1'b0};
    vt[8] = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
    vt[9] = '{1'b1, 1'b0, 1'b1, 2'd2, 32'h0,        32'h0, 1'b0};

    for (int j = 0; j < 8; j++) h[j] = '0;
    for (int e = 0; e < 3; e++) begin
      m_deb[e] = '0; m_dly[e] = '0; m_ec[e] = '0; m_mask[e] = '0; m_rd[e] = '0;
    end

    // Register access after reset with in_port idle.
    inp = '0;
    for (int i = 0; i < 10; i++) begin
      rst_n = vt[i].rst_n;
      bus(vt[i].cs, vt[i].wn, vt[i].addr, vt[i].wd);
      tick();
      chk($sformatf("vec%0d_rd", i), rd[0], vt[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'b0, irq[0]}, {31'b0, vt[i].exp_irq});
    end
    for (int a = 0; a < 4; a++) begin
      bus(1'b0, 1'b1, 2'(a), 32'h0);
      tick();
      tick();
      chk($sformatf("idle_addr%0d", a), rd[0], 32'h0);
    end

    // Latency: mask bit0, raise in_port[0] before E0; capture and irq at E6.
    bus(1'b1, 1'b0, 2'd1, 32'h1);
    tick();
    bus(1'b0, 1'b1, 2'd3, 32'h0);
    inp = 4'h1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("lat_irq_E%0d", k), {31'b0, irq[0]}, {31'b0, k >= 6});
      chk($sformatf("lat_rd_E%0d", k), rd[0], (k >= 7) ? 32'h1 : 32'h0);
    end
    chk("lat_fall_no_irq", {31'b0, irq[1]}, 32'h0);

    // Masking and write-1-to-clear.
    bus(1'b1, 1'b0, 2'd1, 32'h0);
    tick();
    chk("mask0_irq", {31'b0, irq[0]}, 32'h0);
    bus(1'b0, 1'b1, 2'd3, 32'h0);
    tick();
    chk("mask0_ec", rd[0], 32'h1);
    bus(1'b1, 1'b0, 2'd1, 32'h1);
    tick();
    chk("mask1_irq", {31'b0, irq[0]}, 32'h1);
    bus(1'b1, 1'b0, 2'd3, 32'h1);
    tick();
    chk("w1c_irq", {31'b0, irq[0]}, 32'h0);
    bus(1'b0, 1'b1, 2'd3, 32'h0);
    tick();
    chk("w1c_ec", rd[0], 32'h0);

    // Glitch of 3 cycles on bit2 is rejected; a long pulse is captured.
    inp = 4'h5;
    for (int k = 0; k < 3; k++) tick();
    inp = 4'h1;
    for (int k = 0; k < 10; k++) tick();
    chk("glitch_ec", rd[0], 32'h0);
    bus(1'b0, 1'b1, 2'd0, 32'h0);
    tick();
    chk("glitch_data", rd[0], 32'h1);
    inp = 4'h5;
    bus(1'b0, 1'b1, 2'd3, 32'h0);
    for (int k = 0; k < 9; k++) tick();
    chk("long_ec", rd[0], 32'h4);
    chk("long_irq", {31'b0, irq[0]}, 32'h0);

    // Clear collides with a new rising edge on bit1 at E6: set wins.
    bus(1'b1, 1'b0, 2'd3, 32'hF);
    tick();
    bus(1'b0, 1'b1, 2'd3, 32'h0);
    inp = 4'h7;
    for (int k = 0; k < 6; k++) tick();
    bus(1'b1, 1'b0, 2'd3, 32'h2);
    tick();
    bus(1'b0, 1'b1, 2'd3, 32'h0);
    tick();
    chk("collide_rise", rd[0], 32'h2);
    chk("collide_any", rd[2], 32'h2);
    chk("collide_fall", rd[1], 32'h0);

    // Falling edge on bit2: only the falling and any-edge instances capture it.
    inp = 4'h3;
    for (int k = 0; k < 9; k++) tick();
    chk("fall_rise_inst", rd[0], 32'h2);
    chk("fall_fall_inst", rd[1], 32'h4);
    chk("fall_any_inst", rd[2], 32'h6);

    // Reset while irq is high and a debounce (bit3) is mid-count.
    bus(1'b1, 1'b0, 2'd1, 32'h2);
    tick();
    chk("pre_rst_irq", {31'b0, irq[0]}, 32'h1);
    bus(1'b0, 1'b1, 2'd0, 32'h0);
    inp = 4'hB;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_irq", {31'b0, irq[0]}, 32'h0);
    chk("rst_rd", rd[0], 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("post_rst_data_E%0d", k), rd[0], (k >= 6) ? 32'hB : 32'h0);
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) inp[b] = ~inp[b];
      bus($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1 ? 32'($urandom) : 32'h0);
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
